// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmit state encoding, baud divisor helper.
// No logic; constants and a pure function only.
// Used by the transmitter now and by the receiver later.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // sysclk cycles per line bit (integer division, truncating)
  function automatic int calc_div(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_mem.sv
// Synchronous FIFO with push/pop, full/empty flags and occupancy count.
// Latency: pushed word is visible at the head one edge after the push.
// Backpressure: push ignored while full (even on a same-edge pop), pop ignored while empty.
module uart_tx_fifo_mem #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [DW-1:0]              i_data,
  input  logic                       i_pop,
  output logic [DW-1:0]              o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push_ok;
  logic          w_pop_ok;

  assign o_full    = (r_count == L_FULL);
  assign o_empty   = (r_count == '0);
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;
  assign o_data    = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  // Storage is not reset: a reset only discards contents by clearing the pointers.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks push minus pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with baud divider and transmit FIFO; configurable data/parity/stop bits.
// Latency: word pushed into an empty idle FIFO is popped next edge; start bit begins then.
// Backpressure: tx_ready low whenever the FIFO is full; frames run back-to-back while data waits.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          sysclk,
  input  logic                          reset,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx_busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          UART_TX
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE);
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] L_TICK      = CW'(DIV - 1);
  localparam logic [2:0]    L_LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0]    L_LAST_STOP = 3'(STOP_BITS - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CW-1:0]        r_baud;
  logic [2:0]           r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par;
  logic                 w_tick;
  logic                 w_pop;
  logic                 w_done;
  logic                 w_tx;
  logic                 w_full;
  logic                 w_empty;
  logic [DATA_BITS-1:0] w_head;

  uart_tx_fifo_mem #(
    .DW    (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (sysclk),
    .rst     (reset),
    .i_push  (tx_valid),
    .i_data  (tx_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (fifo_count)
  );

  assign w_tick   = (r_baud == L_TICK);
  assign tx_ready = !w_full;
  assign tx_done  = w_done;
  assign UART_TX  = w_tx;
  assign tx_busy  = (r_state != S_IDLE) || (fifo_count != '0);

  // State register.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state, FIFO pop, line level and end-of-frame pulse.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_done      = 1'b0;
    w_tx        = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        w_tx = 1'b0;
        if (w_tick) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        w_tx = r_shift[0];
        if (w_tick && (r_idx == L_LAST_DATA))
          w_state_nxt = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        w_tx = r_par;
        if (w_tick) w_state_nxt = S_STOP;
      end
      S_STOP: begin
        if (w_tick && (r_idx == L_LAST_STOP)) begin
          w_done = 1'b1;
          // Chain straight into the next start bit when more data is queued.
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = S_START;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Baud counter, bit/stop index and shift register; counter restarts at every frame start.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      r_baud  <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
    end else begin
      if (w_pop) begin
        r_shift <= w_head;
        r_par   <= (PARITY == PAR_EVEN) ? ^w_head : ~^w_head;
      end else if ((r_state == S_DATA) && w_tick) begin
        r_shift <= r_shift >> 1;
      end

      if ((w_state_nxt == S_IDLE) || w_pop || w_tick) r_baud <= '0;
      else                                             r_baud <= r_baud + 1'b1;

      if (w_state_nxt != r_state) r_idx <= '0;
      else if (w_tick)            r_idx <= r_idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: an 8N1 instance and a 7E2 instance, both DIV=4, depth 4.
// A queue-based line model predicts every output each cycle; directed tests pin latencies.
// Randomized valid/data with varying load and occasional mid-stream resets.
module tb_uart_tx_fifo;

  localparam int DIV   = 4;
  localparam int DEPTH = 4;

  typedef bit bitq_t[$];

  logic       sysclk = 1'b0;
  logic       rst    = 1'b0;

  logic       valid_a = 1'b0;
  logic [7:0] data_a  = 8'h00;
  logic       ready_a, busy_a, done_a, tx_a;
  logic [2:0] count_a;

  logic       valid_b = 1'b0;
  logic [6:0] data_b  = 7'h00;
  logic       ready_b, busy_b, done_b, tx_b;
  logic [2:0] count_b;

  int checks   = 0;
  int failures = 0;

  uart_tx_fifo #(
    .CLK_FREQ(16), .BAUD_RATE(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)
  ) u_dut_a (
    .sysclk(sysclk), .reset(rst), .tx_data(data_a), .tx_valid(valid_a),
    .tx_ready(ready_a), .tx_busy(busy_a), .tx_done(done_a), .fifo_count(count_a), .UART_TX(tx_a)
  );

  uart_tx_fifo #(
    .CLK_FREQ(16), .BAUD_RATE(4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)
  ) u_dut_b (
    .sysclk(sysclk), .reset(rst), .tx_data(data_b), .tx_valid(valid_b),
    .tx_ready(ready_b), .tx_busy(busy_b), .tx_done(done_b), .fifo_count(count_b), .UART_TX(tx_b)
  );

  always #5 sysclk = ~sysclk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Line levels of one frame, one entry per bit, first bit on the wire first.
  function automatic bitq_t frame_bits(input int unsigned d, input int nb, input int par, input int sb);
    bitq_t q;
    int ones;
    ones = 0;
    q.push_back(1'b0);
    for (int i = 0; i < nb; i++) begin
      q.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (par == 2) q.push_back((ones % 2) == 1);
    if (par == 1) q.push_back((ones % 2) == 0);
    for (int i = 0; i < sb; i++) q.push_back(1'b1);
    return q;
  endfunction

  function automatic int pack_bits(input bitq_t q);
    int v;
    v = 0;
    foreach (q[i]) v |= int'(q[i]) << i;
    return v;
  endfunction

  // ---------------- behavioural model ----------------
  // mq: words waiting in the FIFO; line: expected pin level for the current and following cycles.
  int    mqa[$];
  int    mqb[$];
  bit    linea[$];
  bit    lineb[$];
  bitq_t fba;
  bitq_t fbb;
  bit    acc_a, acc_b;

  always @(posedge sysclk or posedge rst) begin
    if (rst) begin
      mqa.delete();
      linea.delete();
    end else begin
      acc_a = valid_a && (mqa.size() != DEPTH);
      if (linea.size() != 0) void'(linea.pop_front());
      if ((linea.size() == 0) && (mqa.size() != 0)) begin
        fba = frame_bits(mqa.pop_front(), 8, 0, 1);
        foreach (fba[i]) for (int r = 0; r < DIV; r++) linea.push_back(fba[i]);
      end
      if (acc_a) mqa.push_back(int'(data_a));
    end
  end

  always @(posedge sysclk or posedge rst) begin
    if (rst) begin
      mqb.delete();
      lineb.delete();
    end else begin
      acc_b = valid_b && (mqb.size() != DEPTH);
      if (lineb.size() != 0) void'(lineb.pop_front());
      if ((lineb.size() == 0) && (mqb.size() != 0)) begin
        fbb = frame_bits(mqb.pop_front(), 7, 2, 2);
        foreach (fbb[i]) for (int r = 0; r < DIV; r++) lineb.push_back(fbb[i]);
      end
      if (acc_b) mqb.push_back(int'(data_b));
    end
  end

  // Per-cycle comparison, away from the rising edge.
  always @(negedge sysclk) begin
    chk("a_uart_tx", int'(tx_a),    (linea.size() != 0) ? int'(linea[0]) : 1);
    chk("a_tx_done", int'(done_a),  int'(linea.size() == 1));
    chk("a_tx_busy", int'(busy_a),  int'((linea.size() != 0) || (mqa.size() != 0)));
    chk("a_count",   int'(count_a), mqa.size());
    chk("a_ready",   int'(ready_a), int'(mqa.size() != DEPTH));
    chk("b_uart_tx", int'(tx_b),    (lineb.size() != 0) ? int'(lineb[0]) : 1);
    chk("b_tx_done", int'(done_b),  int'(lineb.size() == 1));
    chk("b_tx_busy", int'(busy_b),  int'((lineb.size() != 0) || (mqb.size() != 0)));
    chk("b_count",   int'(count_b), mqb.size());
    chk("b_ready",   int'(ready_b), int'(mqb.size() != DEPTH));
  end

  // ---------------- directed helpers ----------------
  task automatic one_frame(input bit sel, input int d, input int exp_len, input string tag);
    int n;
    bit seen;
    @(negedge sysclk);
    if (sel) begin valid_b = 1'b1; data_b = 7'(d); end
    else     begin valid_a = 1'b1; data_a = 8'(d); end
    @(negedge sysclk);
    valid_a = 1'b0;
    valid_b = 1'b0;
    chk({tag, "_hold_high"}, int'(sel ? tx_b : tx_a), 1);
    chk({tag, "_count_one"}, int'(sel ? count_b : count_a), 1);
    @(negedge sysclk);
    chk({tag, "_start_low"}, int'(sel ? tx_b : tx_a), 0);
    chk({tag, "_count_zero"}, int'(sel ? count_b : count_a), 0);
    n = 1;
    seen = 0;
    while (!seen && (n < 200)) begin
      if (sel ? done_b : done_a) seen = 1;
      else begin
        @(negedge sysclk);
        n++;
      end
    end
    chk({tag, "_frame_len"}, n, exp_len);
    @(negedge sysclk);
    chk({tag, "_busy_drop"}, int'(sel ? busy_b : busy_a), 0);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((busy_a || busy_b) && (n < 2000)) begin
      @(negedge sysclk);
      n++;
    end
    chk({tag, "_drained"}, int'(n < 2000), 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k, cyc, nd, n, nlow, nbusy, pct;
    bit acc, sawfull;

    #1 rst = 1'b1;
    repeat (2) @(negedge sysclk);
    chk("rst_uart_tx", int'(tx_a), 1);
    chk("rst_count",   int'(count_a), 0);
    chk("rst_ready",   int'(ready_a), 1);
    #2 rst = 1'b0;

    // Model pins: hand-derived frames.
    chk("pin_a5_8n1",  pack_bits(frame_bits(32'hA5, 8, 0, 1)), 32'h34A);
    chk("pin_a5_len",  frame_bits(32'hA5, 8, 0, 1).size(), 10);
    chk("pin_35_7e2",  pack_bits(frame_bits(32'h35, 7, 2, 2)), 32'h66A);
    chk("pin_35_7o2",  pack_bits(frame_bits(32'h35, 7, 1, 2)), 32'h76A);

    // Single frames: latency and total frame length.
    one_frame(1'b0, 32'hA5, 40, "a5");
    one_frame(1'b1, 32'h35, 44, "b35");

    // Six words back-to-back with tx_valid held.
    @(negedge sysclk);
    valid_a = 1'b1; data_a = 8'h01; k = 1; cyc = 0; nd = 0; sawfull = 0;
    while ((k <= 6) && (cyc < 1000)) begin
      acc = ready_a;
      @(negedge sysclk);
      cyc++;
      if (done_a) nd++;
      if (count_a == 3'd4) sawfull = 1;
      if (acc) begin
        k++;
        data_a = 8'(k);
      end
    end
    valid_a = 1'b0;
    while (busy_a && (cyc < 2000)) begin
      @(negedge sysclk);
      cyc++;
      if (done_a) nd++;
    end
    chk("stream_filled", int'(sawfull), 1);
    chk("stream_dones", nd, 6);

    // Fill with the engine busy, then offer 0xFF.
    @(negedge sysclk); valid_a = 1'b1; data_a = 8'h10;
    @(negedge sysclk); valid_a = 1'b0;
    repeat (3) @(negedge sysclk);
    for (int w = 0; w < 4; w++) begin
      valid_a = 1'b1;
      data_a  = 8'(8'h11 + w);
      @(negedge sysclk);
    end
    chk("fill_count", int'(count_a), 4);
    chk("fill_ready", int'(ready_a), 0);
    data_a = 8'hFF;
    n = 0;
    while (!ready_a && (n < 500)) begin
      @(negedge sysclk);
      n++;
    end
    chk("ff_blocked", int'((n >= 20) && (n < 500)), 1);
    @(negedge sysclk);
    valid_a = 1'b0;
    wait_idle("fill");

    // Reset in the middle of data bit 3 with two words queued.
    @(negedge sysclk); valid_a = 1'b1; data_a = 8'h00;
    @(negedge sysclk); data_a = 8'h55;
    @(negedge sysclk); data_a = 8'h66;
    chk("rst_setup_start", int'(tx_a), 0);
    @(negedge sysclk); valid_a = 1'b0;
    repeat (16) @(negedge sysclk);
    chk("pre_rst_tx", int'(tx_a), 0);
    chk("pre_rst_count", int'(count_a), 2);
    @(posedge sysclk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_tx", int'(tx_a), 1);
    chk("async_rst_count", int'(count_a), 0);
    chk("async_rst_busy", int'(busy_a), 0);
    chk("async_rst_ready", int'(ready_a), 1);
    @(negedge sysclk);
    @(posedge sysclk);
    #2 rst = 1'b0;
    nlow = 0; nbusy = 0;
    repeat (60) begin
      @(negedge sysclk);
      if (!tx_a) nlow++;
      if (busy_a) nbusy++;
    end
    chk("post_rst_quiet_tx", nlow, 0);
    chk("post_rst_quiet_busy", nbusy, 0);

    // Randomized traffic on both instances.
    for (int c = 0; c < 4000; c++) begin
      @(negedge sysclk);
      if (c < 1000)      pct = 10;
      else if (c < 2500) pct = 40;
      else               pct = 95;
      valid_a = ($urandom_range(0, 99) < pct);
      data_a  = 8'($urandom);
      valid_b = ($urandom_range(0, 99) < pct);
      data_b  = 7'($urandom);
      if ((c == 1700) || (c == 3300)) begin
        #2 rst = 1'b1;
        @(posedge sysclk);
        #2 rst = 1'b0;
      end
    end
    @(negedge sysclk);
    valid_a = 1'b0;
    valid_b = 1'b0;
    wait_idle("random");

    @(negedge sysclk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
